// File: rtl/div_control_32_pkg.sv
// Shared constants for the divide sequencer: state encoding, default core
// latency and the quotient returned for a zero divisor.
package div_control_32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int          DEFAULT_LATENCY   = 4;
  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_control_32_if.sv
// Request/result and core-side signals of the divide sequencer, plus a debug
// view of the FSM state.
interface div_control_32_if;
  import div_control_32_pkg::*;

  // Handshake: a request is taken on a rising edge where in_start and
  // out_ready are both high; out_done pulses for one cycle per result.
  logic        in_start;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic        out_ready;
  logic        out_done;
  logic [31:0] out_lo;
  logic [31:0] out_hi;
  logic        out_div_by_zero;
  logic [31:0] out_div_dividend;
  logic [31:0] out_div_divisor;
  logic [31:0] in_div_quotient;
  logic [31:0] in_div_remainder;
  state_e      dbg_state;

  modport slave (
    input  in_start, in_dividend, in_divisor, in_div_quotient, in_div_remainder,
    output out_ready, out_done, out_lo, out_hi, out_div_by_zero,
           out_div_dividend, out_div_divisor, dbg_state
  );

  modport master (
    output in_start, in_dividend, in_divisor, in_div_quotient, in_div_remainder,
    input  out_ready, out_done, out_lo, out_hi, out_div_by_zero,
           out_div_dividend, out_div_divisor, dbg_state
  );

endinterface

// File: rtl/div_control_32_negate_32.sv
// Conditional two's-complement negate, used for operand magnitudes and for
// restoring result signs.
module negate_32 (
  input  logic [31:0] in_x,
  input  logic        in_en,
  output logic [31:0] out_y
);

  assign out_y = in_en ? (~in_x + 32'd1) : in_x;

endmodule

// File: rtl/div_control_32.sv
// Signed sequencer around the unsigned pipelined divider core: takes signed
// operands, feeds magnitudes to the core, and sign-corrects quotient/remainder.
module div_control_32
  import div_control_32_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input logic              clk,
  input logic              in_reset_n,
  div_control_32_if.slave  bus
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           q_neg_q, r_neg_q;
  logic           done_q;
  logic           dz_q;
  logic [31:0]    lo_q, hi_q;
  logic [31:0]    div_dividend_q, div_divisor_q;
  logic           load_ops, cap_result, cap_zero;
  logic [31:0]    mag_dividend, mag_divisor, q_fixed, r_fixed;

  negate_32 u_mag_dividend (.in_x(bus.in_dividend), .in_en(bus.in_dividend[31]), .out_y(mag_dividend));
  negate_32 u_mag_divisor  (.in_x(bus.in_divisor),  .in_en(bus.in_divisor[31]),  .out_y(mag_divisor));
  negate_32 u_fix_quotient (.in_x(bus.in_div_quotient),  .in_en(q_neg_q), .out_y(q_fixed));
  negate_32 u_fix_remainder(.in_x(bus.in_div_remainder), .in_en(r_neg_q), .out_y(r_fixed));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_ops   = 1'b0;
    cap_result = 1'b0;
    cap_zero   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_start) begin
          // A zero divisor never touches the core; answer on the next edge.
          if (bus.in_divisor == 32'd0) begin
            cap_zero = 1'b1;
          end else begin
            load_ops = 1'b1;
            cnt_d    = CW'(LATENCY - 1);
            state_d  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_FIX: begin
        cap_result = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      q_neg_q        <= 1'b0;
      r_neg_q        <= 1'b0;
      done_q         <= 1'b0;
      dz_q           <= 1'b0;
      lo_q           <= 32'd0;
      hi_q           <= 32'd0;
      div_dividend_q <= 32'd0;
      div_divisor_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= cap_result | cap_zero;
      // Core operands stay frozen outside of an accept: the core samples
      // different dividend bytes in different pipeline stages.
      if (load_ops) begin
        div_dividend_q <= mag_dividend;
        div_divisor_q  <= mag_divisor;
        q_neg_q        <= bus.in_dividend[31] ^ bus.in_divisor[31];
        r_neg_q        <= bus.in_dividend[31];
      end
      if (cap_zero) begin
        lo_q <= DIV_ZERO_QUOTIENT;
        hi_q <= bus.in_dividend;
        dz_q <= 1'b1;
      end
      if (cap_result) begin
        lo_q <= q_fixed;
        hi_q <= r_fixed;
        dz_q <= 1'b0;
      end
    end
  end

  assign bus.out_ready        = (state_q == ST_IDLE);
  assign bus.out_done         = done_q;
  assign bus.out_lo           = lo_q;
  assign bus.out_hi           = hi_q;
  assign bus.out_div_by_zero  = dz_q;
  assign bus.out_div_dividend = div_dividend_q;
  assign bus.out_div_divisor  = div_divisor_q;
  assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_div_control_32.sv
// Directed bench for div_control_32 with a behavioural 4-stage unsigned core.
module tb_div_control_32;
  import div_control_32_pkg::*;

  logic clk;
  logic in_reset_n;
  int   checks = 0;
  int   errors = 0;

  div_control_32_if bus ();

  div_control_32 #(.LATENCY(4)) dut (
    .clk        (clk),
    .in_reset_n (in_reset_n),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- core model ----------------
  // Dividend is taken from the third pipeline stage, divisor from the live
  // input: correct results need both held stable for the whole latency.
  logic [31:0] a_pipe [0:2];
  logic [31:0] core_q = 32'd0;
  logic [31:0] core_r = 32'd0;
  initial begin
    a_pipe[0] = 32'd0; a_pipe[1] = 32'd0; a_pipe[2] = 32'd0;
  end
  always @(posedge clk) begin
    a_pipe[0] <= bus.out_div_dividend;
    a_pipe[1] <= a_pipe[0];
    a_pipe[2] <= a_pipe[1];
    if (bus.out_div_divisor != 32'd0) begin
      core_q <= a_pipe[2] / bus.out_div_divisor;
      core_r <= a_pipe[2] % bus.out_div_divisor;
    end else begin
      core_q <= 32'd0;
      core_r <= 32'd0;
    end
  end
  assign bus.in_div_quotient  = core_q;
  assign bus.in_div_remainder = core_r;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at a negedge after the result was checked.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input bit disturb);
    int lat;
    logic [31:0] e_lo, e_hi, e_dz;
    e_lo = exp_q.pop_front();
    e_hi = exp_q.pop_front();
    e_dz = exp_q.pop_front();
    check32({tag, "_ready_pre"}, {31'd0, bus.out_ready}, 32'd1);
    bus.in_start    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    @(negedge clk);
    bus.in_start = 1'b0;
    lat = 0;
    while (!bus.out_done && lat < 20) begin
      if (disturb && lat == 2) begin
        bus.in_start    = 1'b1;
        bus.in_dividend = 32'd999;
        bus.in_divisor  = 32'd1;
      end else if (disturb && lat == 3) begin
        bus.in_start    = 1'b0;
        bus.in_dividend = 32'd12345;
      end
      @(negedge clk);
      lat++;
    end
    bus.in_start = 1'b0;
    check32({tag, "_done"},    {31'd0, bus.out_done}, 32'd1);
    check32({tag, "_latency"}, lat, exp_lat);
    check32({tag, "_lo"},      bus.out_lo, e_lo);
    check32({tag, "_hi"},      bus.out_hi, e_hi);
    check32({tag, "_dz"},      {31'd0, bus.out_div_by_zero}, e_dz);
    check32({tag, "_ready"},   {31'd0, bus.out_ready}, 32'd1);
    @(negedge clk);
    check32({tag, "_done_pulse"}, {31'd0, bus.out_done}, 32'd0);
    check32({tag, "_lo_hold"},    bus.out_lo, e_lo);
  endtask

  task automatic expect_result(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] dz);
    exp_q.push_back(lo);
    exp_q.push_back(hi);
    exp_q.push_back(dz);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.in_start    = 1'b0;
    bus.in_dividend = 32'd0;
    bus.in_divisor  = 32'd0;
    in_reset_n      = 1'b0;
    repeat (2) @(negedge clk);
    check32("rst_ready", {31'd0, bus.out_ready}, 32'd1);
    check32("rst_done",  {31'd0, bus.out_done},  32'd0);
    check32("rst_lo",    bus.out_lo, 32'd0);
    check32("rst_hi",    bus.out_hi, 32'd0);
    check32("rst_dz",    {31'd0, bus.out_div_by_zero}, 32'd0);
    check32("rst_ddvd",  bus.out_div_dividend, 32'd0);
    in_reset_n = 1'b1;
    @(negedge clk);

    expect_result(32'd7, 32'd2, 32'd0);
    run_div("p30d4", 32'd30, 32'd4, 5, 1'b0);
    expect_result(32'hFFFF_FFFD, 32'd1, 32'd0);
    run_div("p10dm3", 32'd10, 32'hFFFF_FFFD, 5, 1'b0);
    expect_result(32'hFFFF_FF5A, 32'hFFFF_FFFE, 32'd0);
    run_div("m500d3", 32'hFFFF_FE0C, 32'd3, 5, 1'b0);
    expect_result(32'd11, 32'hFFFF_FFFF, 32'd0);
    run_div("m100dm9", 32'hFFFF_FF9C, 32'hFFFF_FFF7, 5, 1'b0);
    expect_result(32'hFFFF_FFFF, 32'd1234, 32'd1);
    run_div("dz1234", 32'd1234, 32'd0, 0, 1'b0);
    expect_result(32'd1, 32'd0, 32'd0);
    run_div("p7d7", 32'd7, 32'd7, 5, 1'b0);
    expect_result(32'h8000_0000, 32'd0, 32'd0);
    run_div("minm1", 32'h8000_0000, 32'hFFFF_FFFF, 5, 1'b0);
    expect_result(32'hC000_0000, 32'd0, 32'd0);
    run_div("mind2", 32'h8000_0000, 32'd2, 5, 1'b0);

    // Start pulse and operand change during BUSY must not disturb 100/7.
    expect_result(32'd14, 32'd2, 32'd0);
    run_div("busy_ign", 32'd100, 32'd7, 5, 1'b1);
    begin
      int extra_done = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus.out_done) extra_done++;
      end
      check32("busy_no_queue", extra_done, 32'd0);
    end

    // Reset during the second BUSY cycle aborts without a result.
    bus.in_start    = 1'b1;
    bus.in_dividend = 32'd30;
    bus.in_divisor  = 32'd4;
    @(negedge clk);
    bus.in_start = 1'b0;
    check32("abort_busy", {31'd0, bus.out_ready}, 32'd0);
    @(negedge clk);
    in_reset_n = 1'b0;
    #1;
    check32("abort_lo",    bus.out_lo, 32'd0);
    check32("abort_hi",    bus.out_hi, 32'd0);
    check32("abort_done",  {31'd0, bus.out_done}, 32'd0);
    check32("abort_ready", {31'd0, bus.out_ready}, 32'd1);
    check32("abort_ddvr",  bus.out_div_divisor, 32'd0);
    @(negedge clk);
    in_reset_n = 1'b1;
    begin
      int late_done = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus.out_done) late_done++;
      end
      check32("abort_no_done", late_done, 32'd0);
    end
    check32("abort_ready_after", {31'd0, bus.out_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
